// File: rtl/fifo_srl_arb.sv
// fifo_srl_arb: round-robin drain of N first-word-fall-through SRL FIFOs into
// one shared downstream FIFO write port, through a one-entry registered stage.
//
// Optional feature macro: FIFO_SRL_ARB_PKT_LOCK_EN
//   defined   - a packet (words up to in_last = 1) from one port is never
//               interleaved with words from other ports
//   undefined - per-word round-robin; in_last only travels to out_last
//
// Ports
//   clk, rstn           clock, synchronous active-low reset
//   in_data  [N*WIDTH]  head words, port k at [k*WIDTH +: WIDTH]
//   in_last  [N]        end-of-packet flag of each head word
//   in_empty [N]        input FIFO empty flags
//   in_rden  [N]        pop strobes, one-hot or zero
//   out_data/out_last   staged word and its end-of-packet flag
//   out_src             input index the staged word came from
//   out_wren            downstream write strobe
//   out_full            downstream full flag
//   busy                stage holds a word or a packet lock is open
module fifo_srl_arb #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LOG2_N = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [(WIDTH << LOG2_N)-1:0]    in_data,
    input  logic [(1 << LOG2_N)-1:0]        in_last,
    input  logic [(1 << LOG2_N)-1:0]        in_empty,
    output logic [(1 << LOG2_N)-1:0]        in_rden,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_last,
    output logic [LOG2_N-1:0]               out_src,
    output logic                            out_wren,
    input  logic                            out_full,
    output logic                            busy
);

    localparam int unsigned N = 1 << LOG2_N;

    typedef enum logic {ARB, LOCK} state_t;

    state_t             state_q, state_d;
    logic [LOG2_N-1:0]  ptr_q;
    logic [LOG2_N-1:0]  lock_q;
    logic               lock_load;

    logic               st_valid;
    logic [WIDTH-1:0]   st_data;
    logic               st_last;
    logic [LOG2_N-1:0]  st_src;

    logic [WIDTH-1:0]   in_word [N];
    logic [LOG2_N-1:0]  rr_idx;
    logic [LOG2_N-1:0]  rr_sel;
    logic               rr_valid;
    logic [LOG2_N-1:0]  sel;
    logic               sel_valid;
    logic               ready;
    logic               pop;

    // Split the flat data bus into per-port words
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            in_word[k] = in_data[k*WIDTH +: WIDTH];
        end
    end

    // Round-robin scan starting after the last granted port; ptr itself is last
    always_comb begin
        rr_idx   = '0;
        rr_sel   = '0;
        rr_valid = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            rr_idx = ptr_q + LOG2_N'(i);
            if (!rr_valid && !in_empty[rr_idx]) begin
                rr_sel   = rr_idx;
                rr_valid = 1'b1;
            end
        end
    end

    // Stage accepts a word when empty or when it drains this cycle
    assign ready = ~st_valid | ~out_full;

    // Next-state, grant select and pop decision
    always_comb begin
        state_d   = state_q;
        lock_load = 1'b0;
        sel       = rr_sel;
        sel_valid = rr_valid;
        if (state_q == LOCK) begin
            sel       = lock_q;
            sel_valid = ~in_empty[lock_q];
        end
        // No pop during reset: the stage is cleared at this edge and the word would be lost
        pop = ready & sel_valid & rstn;
`ifdef FIFO_SRL_ARB_PKT_LOCK_EN
        if (pop) begin
            case (state_q)
                ARB: begin
                    if (!in_last[sel]) begin
                        state_d   = LOCK;
                        lock_load = 1'b1;
                    end
                end
                LOCK: begin
                    if (in_last[sel]) begin
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
`endif
    end

    // Pop strobe to the selected port only
    always_comb begin
        in_rden      = '0;
        in_rden[sel] = pop;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage, round-robin pointer and lock port
    always_ff @(posedge clk) begin
        if (!rstn) begin
            st_valid <= 1'b0;
            st_data  <= '0;
            st_last  <= 1'b0;
            st_src   <= '0;
            ptr_q    <= '1;
            lock_q   <= '0;
        end else begin
            if (pop) begin
                st_valid <= 1'b1;
                st_data  <= in_word[sel];
                st_last  <= in_last[sel];
                st_src   <= sel;
                ptr_q    <= sel;
            end else if (out_wren) begin
                st_valid <= 1'b0;
            end
            if (lock_load) begin
                lock_q <= sel;
            end
        end
    end

    assign out_data = st_data;
    assign out_last = st_last;
    assign out_src  = st_src;
    // The staged word is being dropped by reset, so it is not written either
    assign out_wren = st_valid & ~out_full & rstn;

`ifdef FIFO_SRL_ARB_PKT_LOCK_EN
    assign busy = st_valid | (state_q == LOCK);
`else
    assign busy = st_valid;
`endif

endmodule
